// File: rtl/dnn_stream_dma.sv
// Host-side stream DMA: SRAM -> src stream transmitter and dst stream -> SRAM scatter receiver.
// Define DMA_LEN_CHECK_EN to enable RX length checking on rx_err (default: rx_err tied low).
module dnn_stream_dma #(
   parameter int DW     = 32,
   parameter int AW     = 16,
   parameter int FIFO_D = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            tx_start,
   input  logic [AW-1:0]   tx_base,
   input  logic [AW-1:0]   tx_len,
   output logic            tx_busy,
   output logic            tx_done,
   output logic            rd_en,
   output logic [AW-1:0]   rd_addr,
   input  logic [4*DW-1:0] rd_data,
   output logic            src_valid,
   output logic [DW-1:0]   src_data0,
   output logic [DW-1:0]   src_data1,
   output logic [DW-1:0]   src_data2,
   output logic [DW-1:0]   src_data3,
   output logic            src_last,
   input  logic            src_ready,
   input  logic            rx_start,
   input  logic [AW-1:0]   rx_base,
   input  logic [AW-1:0]   rx_len,
   output logic            rx_busy,
   output logic            rx_done,
   output logic [AW-1:0]   rx_count,
   output logic            rx_err,
   input  logic            dst_valid,
   input  logic [DW-1:0]   dst_data0,
   input  logic [DW-1:0]   dst_data1,
   input  logic [15:0]     dst_ptr0,
   input  logic [15:0]     dst_ptr1,
   input  logic            dst_last,
   output logic            dst_ready,
   output logic            wr_en0,
   output logic            wr_en1,
   output logic [AW-1:0]   wr_addr0,
   output logic [AW-1:0]   wr_addr1,
   output logic [DW-1:0]   wr_data0,
   output logic [DW-1:0]   wr_data1
);

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   localparam int PW  = $clog2(FIFO_D);
   localparam int CW  = PW + 1;
   localparam int OW  = PW + 2;
   localparam int AW1 = AW + 1;

   // ------------------------------------------------------------------ TX
   state_t          tx_state, tx_state_nx;
   logic [AW-1:0]   tx_base_q, tx_len_q, tx_issued, tx_sent;
   logic [4*DW-1:0] fifo_mem [FIFO_D];
   logic [PW-1:0]   fifo_wp, fifo_rp;
   logic [CW-1:0]   fifo_count;
   logic            rd_pending;
   logic            tx_pop, tx_last_hs;
   logic [OW-1:0]   tx_occ;
   logic [4*DW-1:0] head;

   // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tx_state <= S_IDLE;
      else     tx_state <= tx_state_nx;
   end

   always_comb begin
      tx_state_nx = tx_state;
      case (tx_state)
         S_IDLE: if (tx_start && tx_len != '0) tx_state_nx = S_RUN;
         S_RUN:  if (tx_last_hs)               tx_state_nx = S_IDLE;
      endcase
   end

   // NOTE: every signal gets a value on every path through this block, so no latches are inferred.
   always_comb begin
      tx_busy    = (tx_state == S_RUN);
      src_valid  = (fifo_count != '0);
      head       = src_valid ? fifo_mem[fifo_rp] : '0;
      src_last   = src_valid && (tx_sent == tx_len_q - AW'(1));
      tx_pop     = src_valid && src_ready;
      tx_last_hs = tx_pop && src_last;
      // Slots committed after this edge; a read may only be issued if one stays free.
      tx_occ     = OW'(fifo_count) + OW'(rd_pending) - OW'(tx_pop);
      rd_en      = tx_busy && (tx_issued < tx_len_q) && (tx_occ < OW'(FIFO_D));
      rd_addr    = tx_base_q + tx_issued;
   end

   assign src_data0 = head[0*DW +: DW];
   assign src_data1 = head[1*DW +: DW];
   assign src_data2 = head[2*DW +: DW];
   assign src_data3 = head[3*DW +: DW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_base_q  <= '0;
         tx_len_q   <= '0;
         tx_issued  <= '0;
         tx_sent    <= '0;
         fifo_wp    <= '0;
         fifo_rp    <= '0;
         fifo_count <= '0;
         rd_pending <= 1'b0;
         tx_done    <= 1'b0;
      end else begin
         tx_done    <= tx_last_hs;
         rd_pending <= rd_en;
         if (tx_state == S_IDLE && tx_start) begin
            tx_base_q <= tx_base;
            tx_len_q  <= tx_len;
            tx_issued <= '0;
            tx_sent   <= '0;
            tx_done   <= (tx_len == '0);
         end
         if (rd_en)      tx_issued <= tx_issued + AW'(1);
         if (rd_pending) fifo_wp   <= fifo_wp + PW'(1);
         if (tx_pop) begin
            fifo_rp <= fifo_rp + PW'(1);
            tx_sent <= tx_sent + AW'(1);
         end
         fifo_count <= fifo_count + CW'(rd_pending) - CW'(tx_pop);
      end
   end

   // NOTE: the beat storage has no reset; head is gated by src_valid so unwritten slots never leak.
   always_ff @(posedge clk) begin
      if (rd_pending) fifo_mem[fifo_wp] <= rd_data;
   end

   // ------------------------------------------------------------------ RX
   state_t        rx_state, rx_state_nx;
   logic [AW-1:0] rx_base_q, rx_waddr0, rx_waddr1;
   logic          rx_accept;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rx_state <= S_IDLE;
      else     rx_state <= rx_state_nx;
   end

   always_comb begin
      rx_state_nx = rx_state;
      case (rx_state)
         S_IDLE: if (rx_start)              rx_state_nx = S_RUN;
         S_RUN:  if (rx_accept && dst_last) rx_state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      rx_busy   = (rx_state == S_RUN);
      dst_ready = rx_busy;
      rx_accept = dst_valid && dst_ready;
      rx_waddr0 = rx_base_q + AW'(dst_ptr0);
      rx_waddr1 = rx_base_q + AW'(dst_ptr1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_base_q <= '0;
         rx_count  <= '0;
         rx_done   <= 1'b0;
         wr_en0    <= 1'b0;
         wr_en1    <= 1'b0;
         wr_addr0  <= '0;
         wr_addr1  <= '0;
         wr_data0  <= '0;
         wr_data1  <= '0;
      end else begin
         wr_en0  <= 1'b0;
         wr_en1  <= 1'b0;
         rx_done <= 1'b0;
         if (rx_state == S_IDLE && rx_start) begin
            rx_base_q <= rx_base;
            rx_count  <= '0;
         end
         if (rx_accept) begin
            // Colliding lanes: lane1 wins, so lane0's write is dropped.
            wr_en0   <= (rx_waddr0 != rx_waddr1);
            wr_en1   <= 1'b1;
            wr_addr0 <= rx_waddr0;
            wr_addr1 <= rx_waddr1;
            wr_data0 <= dst_data0;
            wr_data1 <= dst_data1;
            rx_count <= (&rx_count) ? rx_count : rx_count + AW'(1);
            rx_done  <= dst_last;
         end
      end
   end

`ifdef DMA_LEN_CHECK_EN
   logic [AW-1:0] rx_len_q;
   logic [AW:0]   rx_next_cnt;
   logic          rx_len_bad;

   always_comb begin
      rx_next_cnt = {1'b0, rx_count} + AW1'(1);
      // Short job on the last beat, or the expected count reached with more to come.
      rx_len_bad  = dst_last ? (rx_next_cnt != {1'b0, rx_len_q})
                             : (rx_next_cnt == {1'b0, rx_len_q});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_len_q <= '0;
         rx_err   <= 1'b0;
      end else if (rx_state == S_IDLE && rx_start) begin
         rx_len_q <= rx_len;
         rx_err   <= 1'b0;
      end else if (rx_accept && rx_len_bad) begin
         rx_err   <= 1'b1;
      end
   end
`else
   logic rx_len_unused;
   assign rx_len_unused = ^rx_len;
   assign rx_err        = 1'b0;
`endif

endmodule
